// File: rtl/mips_pkg.sv
// Shared constants and load-FSM encoding for the MIPS data-memory path.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int AWIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } ld_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous write, one-cycle synchronous read, one access per cycle.
// Contents are never reset.
module dmem_ram
  import mips_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdat,
  output logic [WORD_W-1:0] o_rdat
);

  logic [WORD_W-1:0] r_mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
    if (i_re) o_rdat <= r_mem[i_addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data memory front end: store buffer with youngest-match load forwarding,
// background drain into a single-port RAM, and a two-state load FSM for RAM misses.
module dmem_resp
  import mips_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int AWIDTH   = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwritem,
  input  logic              memtoregm,
  input  logic [WORD_W-1:0] aluoutm,
  input  logic [WORD_W-1:0] writedatam,
  output logic [WORD_W-1:0] readdatam,
  output logic              stallm,
  output logic              wb_empty
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0] r_wb_idx [WB_DEPTH];
  logic [WORD_W-1:0] r_wb_dat [WB_DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  ld_state_t         r_state;

  logic [AWIDTH-1:0] w_idx;
  logic              w_store, w_load, w_full, w_hit, w_rd_issue, w_enq, w_drain;
  logic [WORD_W-1:0] w_fwd, w_ram_rdat;
  logic [AWIDTH-1:0] w_ram_addr;
  logic              w_unused_addr;

  assign w_idx         = aluoutm[AWIDTH+1:2];
  assign w_unused_addr = ^{aluoutm[WORD_W-1:AWIDTH+2], aluoutm[1:0]};

  assign w_store = memwritem;
  assign w_load  = memtoregm & ~memwritem;
  assign w_full  = (r_count == CW'(WB_DEPTH));

  // Walk oldest to youngest so the last hit is the most recent store.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_wb_idx[r_head + PW'(i)] == w_idx)) begin
        w_hit = 1'b1;
        w_fwd = r_wb_dat[r_head + PW'(i)];
      end
    end
  end

  assign w_rd_issue = rst_n & (r_state == ST_IDLE) & w_load & ~w_hit;
  assign w_enq      = rst_n & w_store & ~w_full;
  assign w_drain    = rst_n & (r_count != '0) & ~w_rd_issue;
  assign w_ram_addr = w_rd_issue ? w_idx : r_wb_idx[r_head];

  // Outputs are forced quiet while reset is held, independent of the request lines.
  assign stallm   = rst_n & (w_store ? w_full : w_rd_issue);
  assign wb_empty = (r_count == '0);

  always_comb begin
    readdatam = '0;
    if (rst_n) begin
      if (r_state == ST_RD)                 readdatam = w_ram_rdat;
      else if (w_load && w_hit && !w_store) readdatam = w_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ST_IDLE;
    end else begin
      if (w_enq)   r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_state <= (r_state == ST_IDLE && w_rd_issue) ? ST_RD : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_wb_idx[r_tail] <= w_idx;
      r_wb_dat[r_tail] <= writedatam;
    end
  end

  dmem_ram #(.AWIDTH(AWIDTH)) u_ram (
    .clk    (clk),
    .i_we   (w_drain),
    .i_re   (w_rd_issue),
    .i_addr (w_ram_addr),
    .i_wdat (r_wb_dat[r_head]),
    .o_rdat (w_ram_rdat)
  );

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized and directed bench for dmem_resp against a queue-based store-buffer model.
module tb_dmem_resp;

  localparam int AW  = 8;
  localparam int WBD = 4;
  localparam int OP_IDLE = 0, OP_ST = 1, OP_LD = 2;

  typedef struct {
    int          idx;
    logic [31:0] d;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memwritem, memtoregm;
  logic [31:0] aluoutm, writedatam, readdatam;
  logic        stallm, wb_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending stores in program order, RAM image, and an outstanding miss.
  st_t         m_q[$];
  logic [31:0] m_ram [2**AW];
  bit          m_rd;
  logic [31:0] m_rdval;

  always #5 clk = ~clk;

  dmem_resp #(.WB_DEPTH(WBD), .AWIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memwritem  (memwritem),
    .memtoregm  (memtoregm),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .readdatam  (readdatam),
    .stallm     (stallm),
    .wb_empty   (wb_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // One clock cycle with the given request; returns whether it was accepted.
  task automatic do_cycle(input int op, input logic [31:0] addr, input logic [31:0] wdat,
                          output bit acc, output logic [31:0] rd);
    logic [31:0] er;
    bit          es, miss, found;
    int          idx;
    @(posedge clk); #1;
    memwritem  = (op == OP_ST);
    memtoregm  = (op == OP_LD);
    aluoutm    = addr;
    writedatam = wdat;
    idx   = int'(addr[AW+1:2]);
    er    = '0;
    es    = 1'b0;
    miss  = 1'b0;
    found = 1'b0;
    if (m_rd) begin
      er   = m_rdval;
      m_rd = 1'b0;
    end else if (op == OP_ST) begin
      es = (m_q.size() == WBD);
    end else if (op == OP_LD) begin
      for (int i = m_q.size() - 1; i >= 0; i--)
        if (!found && m_q[i].idx == idx) begin
          found = 1'b1;
          er    = m_q[i].d;
        end
      if (!found) begin
        es      = 1'b1;
        miss    = 1'b1;
        m_rd    = 1'b1;
        m_rdval = m_ram[idx];
      end
    end
    @(negedge clk);
    chk("stallm", 32'(stallm), 32'(es));
    chk("readdatam", readdatam, er);
    chk("wb_empty", 32'(wb_empty), 32'(m_q.size() == 0));
    rd = readdatam;
    if (!miss && m_q.size() > 0) begin
      m_ram[m_q[0].idx] = m_q[0].d;
      void'(m_q.pop_front());
    end
    if (op == OP_ST && !es) m_q.push_back('{idx: idx, d: wdat});
    acc = !es;
  endtask

  // Holds a request until accepted; reports data and number of stalled cycles.
  task automatic run_req(input int op, input logic [31:0] addr, input logic [31:0] wdat,
                         output logic [31:0] rd, output int stalls);
    bit acc;
    stalls = 0;
    do_cycle(op, addr, wdat, acc, rd);
    while (!acc && stalls < 16) begin
      stalls++;
      do_cycle(op, addr, wdat, acc, rd);
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle_until_empty();
    logic [31:0] rd;
    int          s;
    for (int n = 0; n < 16 && m_q.size() > 0; n++) run_req(OP_IDLE, '0, '0, rd, s);
    run_req(OP_IDLE, '0, '0, rd, s);
  endtask

  initial begin
    logic [31:0] rd, a;
    int          s, op;

    rst_n = 1'b0; memwritem = 1'b0; memtoregm = 1'b1; aluoutm = 32'h10; writedatam = '0;
    m_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stallm", 32'(stallm), 32'd0);
    chk("rst_readdatam", readdatam, 32'd0);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    memtoregm = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 2**AW; i++) run_req(OP_ST, 32'(i) << 2, init_val(i), rd, s);
    idle_until_empty();

    run_req(OP_ST, 32'h10, 32'hDEAD_BEEF, rd, s);
    run_req(OP_LD, 32'h10, '0, rd, s);
    chk("fwd_deadbeef", rd, 32'hDEAD_BEEF);
    chk("fwd_no_stall", 32'(s), 32'd0);

    for (int i = 0; i < 5; i++) run_req(OP_ST, 32'(i * 4), 32'h100 + 32'(i), rd, s);
    for (int i = 0; i < 5; i++) run_req(OP_IDLE, '0, '0, rd, s);

    run_req(OP_ST, 32'h20, 32'h1111_1111, rd, s);
    run_req(OP_ST, 32'h20, 32'h2222_2222, rd, s);
    run_req(OP_LD, 32'h20, '0, rd, s);
    chk("youngest_match", rd, 32'h2222_2222);

    run_req(OP_ST, 32'h40, 32'hCAFE_0001, rd, s);
    idle_until_empty();
    run_req(OP_LD, 32'h40, '0, rd, s);
    chk("ram_load_data", rd, 32'hCAFE_0001);
    chk("ram_load_stalls", 32'(s), 32'd1);

    run_req(OP_ST, 32'h000, 32'h55, rd, s);
    run_req(OP_LD, 32'h400, '0, rd, s);
    chk("alias_fwd", rd, 32'h55);
    idle_until_empty();
    run_req(OP_LD, 32'h400, '0, rd, s);
    chk("alias_ram", rd, 32'h55);

    for (int i = 0; i < 3; i++) run_req(OP_ST, 32'h300 + 32'(i * 4), 32'hBAD0 + 32'(i), rd, s);
    @(posedge clk); #1;
    memwritem = 1'b1; memtoregm = 1'b0; aluoutm = 32'h30C; writedatam = 32'hBAD3;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wb_empty", 32'(wb_empty), 32'd1);
    chk("midrst_stallm", 32'(stallm), 32'd0);
    chk("midrst_readdatam", readdatam, 32'd0);
    m_q.delete();
    m_rd = 1'b0;
    @(negedge clk);
    memwritem = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_req(OP_LD, 32'h300 + 32'(i * 4), '0, rd, s);
    run_req(OP_LD, 32'h30C, '0, rd, s);
    chk("midrst_dropped", rd, init_val(8'hC3));

    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(2, 0));
      a  = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(15, 0)) << 2);
      run_req(op, a, $urandom(), rd, s);
    end
    idle_until_empty();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
